// File: rtl/grid_pkg.sv
// Shared types and tile arithmetic for the grid movement engine.
package grid_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_REQ_Q = 3'd1,
    S_CHK_Q = 3'd2,
    S_REQ_C = 3'd3,
    S_CHK_C = 3'd4
  } step_state_t;

  // Tile coordinates are carried in a fixed-width container so the helper can
  // serve any maze size up to 2**TILE_W tiles; callers cast down to their POS_W.
  localparam int unsigned TILE_W = 16;

  typedef struct packed {
    logic              valid;
    logic [TILE_W-1:0] target;
  } tile_t;

  // Neighbouring tile of pos {row,col} in direction d. Rows never wrap; columns
  // wrap only when wrap is set. DIR_NONE never yields a valid target.
  function automatic tile_t next_tile(input logic [TILE_W-1:0] pos,
                                      input dir_t              d,
                                      input logic              wrap,
                                      input int unsigned       row_bits,
                                      input int unsigned       col_bits);
    logic [TILE_W-1:0] col_mask;
    logic [TILE_W-1:0] row_mask;
    logic [TILE_W-1:0] col;
    logic [TILE_W-1:0] row;
    logic [TILE_W-1:0] ncol;
    logic [TILE_W-1:0] nrow;
    tile_t             t;
    col_mask = TILE_W'((32'd1 << col_bits) - 32'd1);
    row_mask = TILE_W'((32'd1 << row_bits) - 32'd1);
    col      = pos & col_mask;
    row      = (pos >> col_bits) & row_mask;
    ncol     = col;
    nrow     = row;
    t.valid  = 1'b1;
    case (d)
      DIR_UP: begin
        if (row == '0) t.valid = 1'b0;
        else           nrow = row - 1'b1;
      end
      DIR_DOWN: begin
        if (row == row_mask) t.valid = 1'b0;
        else                 nrow = row + 1'b1;
      end
      DIR_LEFT: begin
        if (col == '0) begin
          if (wrap) ncol = col_mask;
          else      t.valid = 1'b0;
        end else begin
          ncol = col - 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (col == col_mask) begin
          if (wrap) ncol = '0;
          else      t.valid = 1'b0;
        end else begin
          ncol = col + 1'b1;
        end
      end
      default: t.valid = 1'b0;
    endcase
    t.target = (nrow << col_bits) | ncol;
    return t;
  endfunction

endpackage

// File: rtl/grid_dir_queue.sv
// Turn buffer: decodes a one-hot {up,down,left,right} request and holds it
// until the mover accepts it (clr) or a newer one-hot request replaces it.
module grid_dir_queue
  import grid_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] dir_req,
  input  logic       clr,
  output dir_t       queued
);

  dir_t req_dir;
  logic req_vld;

  // One-hot decode; zero-hot and multi-hot requests are not turns.
  always_comb begin
    req_dir = DIR_NONE;
    req_vld = 1'b0;
    case (dir_req)
      4'b1000: begin req_dir = DIR_UP;    req_vld = 1'b1; end
      4'b0100: begin req_dir = DIR_DOWN;  req_vld = 1'b1; end
      4'b0010: begin req_dir = DIR_LEFT;  req_vld = 1'b1; end
      4'b0001: begin req_dir = DIR_RIGHT; req_vld = 1'b1; end
      default: begin req_dir = DIR_NONE;  req_vld = 1'b0; end
    endcase
  end

  // Clearing wins over a same-cycle request; a held input reloads next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     queued <= DIR_NONE;
    else if (clr)     queued <= DIR_NONE;
    else if (req_vld) queued <= req_dir;
  end

endmodule

// File: rtl/grid_mover.sv
// Tile-grid movement engine for one sprite: tries the buffered turn first, then
// the current heading, wall-checking each candidate against an external
// synchronous maze ROM (one row per read, one cycle latency).
module grid_mover
  import grid_pkg::*;
#(
  parameter int unsigned                      COL_BITS  = 5,
  parameter int unsigned                      ROW_BITS  = 5,
  parameter logic [ROW_BITS+COL_BITS-1:0]     START_POS = 10'd33,
  parameter bit                               WRAP_EN   = 1'b1
)
(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic                         respawn,
  input  logic                         step_tick,
  input  logic [3:0]                   dir_req,
  output logic [ROW_BITS-1:0]          map_addr,
  input  logic [(1<<COL_BITS)-1:0]     map_data,
  output logic [ROW_BITS+COL_BITS-1:0] pos,
  output dir_t                         dir,
  output logic                         step_done,
  output logic                         blocked
);

  localparam int unsigned POS_W = ROW_BITS + COL_BITS;

  step_state_t state, state_nxt;
  dir_t        queued;
  logic        q_clr;
  logic        acc, acc_nxt;

  logic [POS_W-1:0] pos_nxt;
  dir_t             dir_nxt;
  logic             blocked_nxt;
  logic             done_nxt;

  // Step snapshot taken in S_REQ_Q so both checks see the pre-step sprite state.
  logic [POS_W-1:0] pos_p0;
  dir_t             dir_p0;
  dir_t             qdir_p0;

  logic [POS_W-1:0] q_src_pos;
  dir_t             q_src_dir;
  tile_t            q_tile, c_tile;
  logic [POS_W-1:0] q_pos, c_pos;
  logic [COL_BITS-1:0] q_widx, c_widx;
  logic             q_free, c_free;

  grid_dir_queue u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .dir_req (dir_req),
    .clr     (q_clr),
    .queued  (queued)
  );

  // Queued-turn candidate: live state while addressing the ROM, snapshot while checking.
  always_comb begin
    q_src_pos = (state == S_REQ_Q) ? pos    : pos_p0;
    q_src_dir = (state == S_REQ_Q) ? queued : qdir_p0;
    q_tile    = next_tile(TILE_W'(q_src_pos), q_src_dir, WRAP_EN, ROW_BITS, COL_BITS);
    c_tile    = next_tile(TILE_W'(pos_p0), dir_p0, WRAP_EN, ROW_BITS, COL_BITS);
    q_pos     = POS_W'(q_tile.target);
    c_pos     = POS_W'(c_tile.target);
    // ROM bit for column c sits at MAP_W-1-c, which is ~c for a power-of-two width.
    q_widx    = ~q_pos[COL_BITS-1:0];
    c_widx    = ~c_pos[COL_BITS-1:0];
    q_free    = q_tile.valid & ~map_data[q_widx];
    c_free    = c_tile.valid & ~map_data[c_widx];
  end

  // Step sequencer: next state, ROM address and sprite updates.
  always_comb begin
    state_nxt   = state;
    map_addr    = '0;
    pos_nxt     = pos;
    dir_nxt     = dir;
    acc_nxt     = acc;
    blocked_nxt = blocked;
    done_nxt    = 1'b0;
    q_clr       = 1'b0;
    if (respawn) begin
      state_nxt   = S_WAIT;
      pos_nxt     = START_POS;
      dir_nxt     = DIR_NONE;
      acc_nxt     = 1'b0;
      blocked_nxt = 1'b0;
      q_clr       = 1'b1;
    end else begin
      case (state)
        S_WAIT: begin
          if (run && step_tick) begin
            state_nxt = S_REQ_Q;
            acc_nxt   = 1'b0;
          end
        end
        S_REQ_Q: begin
          map_addr  = q_pos[POS_W-1:COL_BITS];
          state_nxt = S_CHK_Q;
        end
        S_CHK_Q: begin
          if (q_free) begin
            pos_nxt = q_pos;
            dir_nxt = qdir_p0;
            q_clr   = 1'b1;
            acc_nxt = 1'b1;
          end
          state_nxt = S_REQ_C;
        end
        S_REQ_C: begin
          map_addr  = c_pos[POS_W-1:COL_BITS];
          state_nxt = S_CHK_C;
        end
        S_CHK_C: begin
          if (acc) begin
            blocked_nxt = 1'b0;
          end else if (c_free) begin
            pos_nxt     = c_pos;
            blocked_nxt = 1'b0;
          end else begin
            dir_nxt     = DIR_NONE;
            blocked_nxt = 1'b1;
          end
          done_nxt  = 1'b1;
          state_nxt = S_WAIT;
        end
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  // State register and sprite outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_WAIT;
      pos       <= START_POS;
      dir       <= DIR_NONE;
      acc       <= 1'b0;
      blocked   <= 1'b0;
      step_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      dir       <= dir_nxt;
      acc       <= acc_nxt;
      blocked   <= blocked_nxt;
      step_done <= done_nxt;
    end
  end

  // --- stage p0: snapshot of the sprite at the start of a step ---
  always_ff @(posedge clk) begin
    if (state == S_REQ_Q) begin
      pos_p0  <= pos;
      dir_p0  <= dir;
      qdir_p0 <= queued;
    end
  end

endmodule
